button_conditioner: RTL and testbench

//  Front-end for all push-buttons. Takes raw pad inputs and produces clean, debounced levels plus single-cycle press/release pulses.

---
 rtl/btn_pkg.sv | 23 ++
 rtl/button_conditioner_if.sv | 24 ++
 rtl/debounce_channel.sv | 110 +++++++++++
 rtl/button_conditioner.sv | 37 +++
 tb/tb_button_conditioner.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button front-end: board channel indices,
// default channel count, counter sizing helper and the auto-repeat state type.
package btn_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;
    localparam int N_BTN_DEFAULT = 5;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_WAIT_FIRST,
        REP_WAIT_NEXT
    } repState_t;

    // Bits needed to hold every value 0..maxVal.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the pads and the conditioner: raw pad levels in,
// debounced levels and press/release pulses out.
interface button_conditioner_if import btn_pkg::*; #(
    parameter int N_BTN = N_BTN_DEFAULT
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, debounce counter, registered press/release pulses,
// plus hold-to-repeat press pulses when AUTO_REPEAT_EN is defined.
module debounce_channel import btn_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic pressPulse,
    output logic releasePulse
);

    localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncQ1;
    logic             syncQ2;
    logic [CNT_W-1:0] cnt;
    logic             levelDly;

    // Any synchronised sample matching the accepted level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES mismatches flips the level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            syncQ1       <= 1'b0;
            syncQ2       <= 1'b0;
            cnt          <= '0;
            level        <= 1'b0;
            levelDly     <= 1'b0;
            releasePulse <= 1'b0;
        end else begin
            syncQ1 <= raw;
            syncQ2 <= syncQ1;
            if (syncQ2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= syncQ2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            levelDly     <= level;
            releasePulse <= levelDly & ~level;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = cntWidth(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_PERIOD);

    repState_t         repState;
    logic [HOLD_W-1:0] holdCnt;

    // holdCnt counts cycles since the last press pulse; a level drop clears it
    // in the same cycle, so a repeat can never land on the release pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            repState   <= REP_IDLE;
            holdCnt    <= '0;
            pressPulse <= 1'b0;
        end else if (!level) begin
            repState   <= REP_IDLE;
            holdCnt    <= '0;
            pressPulse <= 1'b0;
        end else if (!levelDly) begin
            repState   <= REP_WAIT_FIRST;
            holdCnt    <= HOLD_W'(1);
            pressPulse <= 1'b1;
        end else begin
            pressPulse <= 1'b0;
            holdCnt    <= holdCnt + HOLD_W'(1);
            case (repState)
                REP_WAIT_FIRST: begin
                    if (holdCnt == HOLD_FIRST) begin
                        pressPulse <= 1'b1;
                        holdCnt    <= HOLD_W'(1);
                        repState   <= REP_WAIT_NEXT;
                    end
                end
                REP_WAIT_NEXT: begin
                    if (holdCnt == HOLD_NEXT) begin
                        pressPulse <= 1'b1;
                        holdCnt    <= HOLD_W'(1);
                    end
                end
                default: begin
                    holdCnt <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pressPulse <= 1'b0;
        end else begin
            pressPulse <= level & ~levelDly;
        end
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN raw button pads into clean levels and 1-cycle press/release pulses.
// Optional hold-to-repeat press pulses are built when AUTO_REPEAT_EN is defined.
module button_conditioner import btn_pkg::*; #(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 CLK,
    input  logic                 RST,
    button_conditioner_if.slave  btnIf
);

    // Repeat timing is only consumed by the auto-repeat build, but bad values are rejected in both.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParams
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_chan (
            .CLK          (CLK),
            .RST          (RST),
            .raw          (btnIf.btn_raw[i]),
            .level        (btnIf.btn_level[i]),
            .pressPulse   (btnIf.btn_press[i]),
            .releasePulse (btnIf.btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner; expected pulses are queued
// by a window-based reference model and popped by an independent monitor.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int N    = N_BTN_DEFAULT;
    localparam int DB   = 8;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int MAXC = 8192;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    button_conditioner_if #(.N_BTN(N)) btnIf ();

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .btnIf (btnIf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int ch;
        bit isPress;
    } evt_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    evt_t expQ[$];
    bit   rawAt [N][MAXC];
    int   lastFlipSample [N];
    int   riseCyc [N];
    bit   mLevel [N];
    int   pressCnt [N];
    int   releaseCnt [N];
    int   lastPressCyc [N];
    int   lastReleaseCyc [N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Level flips when the last DB synchronised samples, all newer than the previous flip, disagree with it.
    function automatic bit windowFlips(input int ch, input int s, input bit lvl);
        if (s - DB + 1 <= lastFlipSample[ch]) return 1'b0;
        for (int i = s - DB + 1; i <= s; i++) begin
            if (rawAt[ch][i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: runs on each rising edge and queues pulses due on the next edge.
    always begin
        @(posedge CLK);
        cyc++;
        if (RST) begin
            expQ.delete();
            for (int ch = 0; ch < N; ch++) begin
                mLevel[ch]         = 1'b0;
                lastFlipSample[ch] = cyc;
                riseCyc[ch]        = -1000;
            end
        end else if (cyc < MAXC) begin
            for (int ch = 0; ch < N; ch++) begin
                rawAt[ch][cyc] = btnIf.btn_raw[ch];
                if (windowFlips(ch, cyc - 2, mLevel[ch])) begin
                    mLevel[ch]         = ~mLevel[ch];
                    lastFlipSample[ch] = cyc - 2;
                    if (mLevel[ch]) riseCyc[ch] = cyc;
                    expQ.push_back('{cyc + 1, ch, mLevel[ch]});
                end
`ifdef AUTO_REPEAT_EN
                else if (mLevel[ch] && (cyc - riseCyc[ch]) >= RD &&
                         ((cyc - riseCyc[ch] - RD) % RP) == 0) begin
                    expQ.push_back('{cyc + 1, ch, 1'b1});
                end
`endif
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        logic [N-1:0] expP;
        logic [N-1:0] expR;
        logic [N-1:0] expL;
        evt_t         e;
        @(posedge CLK);
        #1;
        if (RST) begin
            chk("reset_outputs", int'({btnIf.btn_level, btnIf.btn_press, btnIf.btn_release}), 0);
        end else begin
            expP = '0;
            expR = '0;
            while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                if (e.cyc < cyc) chk("stale_event", e.cyc, cyc);
                else if (e.isPress) expP[e.ch] = 1'b1;
                else expR[e.ch] = 1'b1;
            end
            if (|btnIf.btn_press || |btnIf.btn_release || |expP || |expR) begin
                chk("press_vec", int'(btnIf.btn_press), int'(expP));
                chk("release_vec", int'(btnIf.btn_release), int'(expR));
            end
            for (int ch = 0; ch < N; ch++) begin
                expL[ch] = mLevel[ch];
                if (btnIf.btn_press[ch]) begin
                    pressCnt[ch]++;
                    lastPressCyc[ch] = cyc;
                end
                if (btnIf.btn_release[ch]) begin
                    releaseCnt[ch]++;
                    lastReleaseCyc[ch] = cyc;
                end
            end
            chk("level_vec", int'(btnIf.btn_level), int'(expL));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int k;
        int j;
        int p;
        int r;
        int expCnt;
        bit v;
        for (int ch = 0; ch < N; ch++) begin
            pressCnt[ch]       = 0;
            releaseCnt[ch]     = 0;
            lastPressCyc[ch]   = -1;
            lastReleaseCyc[ch] = -1;
        end

        // 1: buttons held through reset appear as fresh presses once reset lifts
        btnIf.btn_raw = '1;
        RST = 1'b1;
        tick(4);
        RST = 1'b0;
        k = cyc;
        tick(15);
        for (int ch = 0; ch < N; ch++) begin
            chk("t1_press_count", pressCnt[ch], 1);
            chk("t1_press_cycle", lastPressCyc[ch], k + 11);
        end
        btnIf.btn_raw = '0;
        tick(15);

        // 2: clean press and release on L
        btnIf.btn_raw[BTN_L] = 1'b1;
        k = cyc;
        tick(15);
        chk("t2_press_cycle", lastPressCyc[BTN_L], k + 11);
        btnIf.btn_raw[BTN_L] = 1'b0;
        k = cyc;
        tick(15);
        chk("t2_release_cycle", lastReleaseCyc[BTN_L], k + 11);

        // 3: bouncing C settles high, exactly one press from the final edge
        p = pressCnt[BTN_C];
        v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v = ~v;
            btnIf.btn_raw[BTN_C] = v;
            tick(3);
        end
        btnIf.btn_raw[BTN_C] = 1'b1;
        k = cyc;
        tick(15);
        chk("t3_press_count", pressCnt[BTN_C] - p, 1);
        chk("t3_press_cycle", lastPressCyc[BTN_C], k + 11);
        btnIf.btn_raw[BTN_C] = 1'b0;
        tick(15);

        // 4: 7-cycle glitch on R is swallowed
        p = pressCnt[BTN_R];
        r = releaseCnt[BTN_R];
        btnIf.btn_raw[BTN_R] = 1'b1;
        tick(7);
        btnIf.btn_raw[BTN_R] = 1'b0;
        tick(15);
        chk("t4_glitch_press", pressCnt[BTN_R] - p, 0);
        chk("t4_glitch_release", releaseCnt[BTN_R] - r, 0);

        // 5: simultaneous U and D, then reset interrupting a debounce on R
        btnIf.btn_raw[BTN_U] = 1'b1;
        btnIf.btn_raw[BTN_D] = 1'b1;
        k = cyc;
        tick(15);
        chk("t5_press_u", lastPressCyc[BTN_U], k + 11);
        chk("t5_press_d", lastPressCyc[BTN_D], k + 11);
        btnIf.btn_raw[BTN_U] = 1'b0;
        btnIf.btn_raw[BTN_D] = 1'b0;
        tick(15);
        p = pressCnt[BTN_R];
        btnIf.btn_raw[BTN_R] = 1'b1;
        tick(5);
        RST = 1'b1;
        tick(2);
        btnIf.btn_raw[BTN_R] = 1'b0;
        tick(1);
        RST = 1'b0;
        tick(20);
        chk("t5_reset_discard", pressCnt[BTN_R] - p, 0);

        // 6: long hold on L
        p = pressCnt[BTN_L];
        btnIf.btn_raw[BTN_L] = 1'b1;
        k = cyc;
        tick(71);
        btnIf.btn_raw[BTN_L] = 1'b0;
        j = cyc;
        tick(20);
        expCnt = 1;
`ifdef AUTO_REPEAT_EN
        for (int t = k + 10 + 1 + RD; t <= j + 10; t += RP) expCnt++;
`endif
        chk("t6_hold_press_count", pressCnt[BTN_L] - p, expCnt);
        chk("t6_release_cycle", lastReleaseCyc[BTN_L], j + 11);

        // Random pad activity with occasional resets
        for (int it = 0; it < 2000; it++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 9) == 0) btnIf.btn_raw[ch] = ~btnIf.btn_raw[ch];
            end
            if ($urandom_range(0, 499) == 0) begin
                RST = 1'b1;
                tick($urandom_range(1, 3));
                RST = 1'b0;
            end
            tick(1);
        end
        btnIf.btn_raw = '0;
        tick(40);
        chk("queue_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
